// File: rtl/rst_seq_ctrl.sv
// Activity watchdog and mapper-reset request sequencer.
// Watches CH asynchronous activity inputs, flags each channel idle after a quiet period, and
// once every enabled channel is idle walks RUN -> DELAY -> REQ, holding rst_req until the
// acknowledge arrives, then waits in ACKED for activity to resume.
module rst_seq_ctrl #(
    parameter int unsigned CH     = 2,
    parameter int unsigned IDLE_W = 7,
    parameter int unsigned DLY_W  = 26,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    act_in,
    input  logic [CH-1:0]    ch_en,
    input  logic             dly_en,
    input  logic             rst_ack,
    output logic [CH-1:0]    idle,
    output logic             sys_rst,
    output logic             rst_req,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] rst_cnt
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDelay = 2'd1,
        StReq   = 2'd2,
        StAcked = 2'd3
    } state_e;

    logic [CH-1:0]     s0_q, s1_q, s2_q;
    logic [CH-1:0]     act_edge;
    logic [IDLE_W-1:0] ctr_q [CH];
    logic [IDLE_W-1:0] ctr_d [CH];
    logic              ack_q;
    state_e            state_q, state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Synchronise the activity inputs and the acknowledge; s0 is the metastability stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q  <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            ack_q <= 1'b0;
        end else begin
            s0_q  <= act_in;
            s1_q  <= s0_q;
            s2_q  <= s1_q;
            ack_q <= rst_ack;
        end
    end

    assign act_edge = s1_q ^ s2_q;

    // Idle counters: clear on edge, count up until the top bit sets, then hold.
    always_comb begin
        idle = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            ctr_d[i] = ctr_q[i];
            if (act_edge[i]) begin
                ctr_d[i] = '0;
            end else if (!ctr_q[i][IDLE_W-1]) begin
                ctr_d[i] = ctr_q[i] + IDLE_W'(1);
            end
            idle[i] = ctr_q[i][IDLE_W-1];
        end
    end

    // Idle counter registers.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < CH; i++) begin
            if (rst) begin
                ctr_q[i] <= '0;
            end else begin
                ctr_q[i] <= ctr_d[i];
            end
        end
    end

    // Disabled channels count as idle, but with nothing enabled there is nothing to watch.
    assign sys_rst = (|ch_en) & (&(idle | ~ch_en));

    // Sequencer next state, delay counter and saturating request counter.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (sys_rst) begin
                    state_d = StDelay;
                    dly_d   = '0;
                end
            end
            StDelay: begin
                if (!sys_rst) begin
                    state_d = StRun;
                end else if (!dly_en || (dly_q[DLY_W-1 -: 2] == 2'b11)) begin
                    state_d = StReq;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            StReq: begin
                // Only the acknowledge leaves REQ; resumed activity does not cancel it.
                if (ack_q) begin
                    state_d = StAcked;
                end
            end
            StAcked: begin
                if (!sys_rst) begin
                    state_d = StRun;
                end
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            dly_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rst_req = (state_q == StReq);
    assign state   = state_q;
    assign rst_cnt = cnt_q;

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Parametrised successor to the single-channel M2 activity watchdog and mapper-reset request logic. Monitors CH asynchronous activity inputs (M2, PPU /OE, etc.) and declares a system reset when every enabled channel has gone quiet. An optional long delay then raises a latched mapper-reset request, held until the menu side acknowledges it. Sits in top beside base_io; rst_req feeds map_rst and rst_ack comes from cfg.map_idx == 255.

Parameters:
CH, 2, number of monitored activity channels
IDLE_W, 7, idle counter width; a channel is idle 2^(IDLE_W-1) cycles after its last detected edge
DLY_W, 26, delay counter width; the delay expires when the top two bits are both 1
CNT_W, 8, width of the saturating reset-event counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
act_in  in  CH  asynchronous activity inputs; any toggle counts as activity
ch_en  in  CH  per-channel enable; a disabled channel is excluded from the idle AND
dly_en  in  1  1 = apply the DLY_W delay before requesting; 0 = request immediately
rst_ack  in  1  level acknowledge from the menu/OS side
idle  out  CH  per-channel idle flag
sys_rst  out  1  all enabled channels idle
rst_req  out  1  latched mapper-reset request
state  out  2  FSM state: RUN=0, DELAY=1, REQ=2, ACKED=3
rst_cnt  out  CNT_W  count of REQ entries, saturating

Behaviour:
- Reset (rst=1 at a clk edge):
  - All sync flops, idle counters, dly_ctr, ack_s and rst_cnt cleared.
  - state=RUN.
  - Outputs: idle=0, sys_rst=0, rst_req=0, rst_cnt=0.
  - Reset mid-operation (any state) behaves the same; a pending request is dropped.
- Per-channel sync and edge detect:
  - s0<=act_in[i]; s1<=s0; s2<=s1; edge_i = s1^s2.
  - An input toggle is seen as an edge 2 cycles after it is first sampled.
- Idle counter ctr_i (IDLE_W bits):
  - On edge_i: ctr_i<=0.
  - Otherwise, while ctr_i[IDLE_W-1]==0: increment. Freezes once the top bit is set; never wraps.
  - idle[i] = ctr_i[IDLE_W-1], combinational from the register.
  - Edge and saturation on the same cycle: the edge wins.
  - After reset with no activity, idle rises 2^(IDLE_W-1) cycles after reset release.
- sys_rst = |(ch_en) & &(idle | ~ch_en). If ch_en == 0, sys_rst = 0.
- ack_s <= rst_ack (one sync stage). The FSM uses ack_s only.
- FSM, registered, evaluated each clk:
  - RUN: if sys_rst, go to DELAY with dly_ctr<=0.
  - DELAY:
    - If !sys_rst: go to RUN (abort; no request, rst_cnt unchanged).
    - Else if !dly_en or dly_ctr[DLY_W-1:DLY_W-2]==2'b11: go to REQ and increment rst_cnt unless it is all-ones.
    - Else dly_ctr++.
    - With dly_en=1, the state spends 3*2^(DLY_W-2)+1 cycles in DELAY. With dly_en=0 it spends 1 cycle.
  - REQ:
    - rst_req=1.
    - If ack_s: go to ACKED. Activity resuming in REQ does not cancel the request.
  - ACKED:
    - If !sys_rst: go to RUN.
    - ack_s is ignored.
- rst_req = (state==REQ), decoded from the state register; no glitch path from inputs.
- ack_s is ignored in RUN, DELAY and ACKED. An ack already high when REQ is entered moves the FSM to ACKED on the next edge, so rst_req is a 1-cycle pulse.
- dly_en and ch_en may change at any time; the new values take effect on the next edge.

Test Plan:
All tests use IDLE_W=4 (idle threshold 8), DLY_W=4 (delay threshold 12) and CNT_W=2.
1. Idle detection:
   - Stimulus: ch_en=01; toggle act_in[0] every 2 cycles for 40 cycles, then hold it.
   - Required: idle[0]=0 and state=RUN while toggling; idle[0] and sys_rst rise exactly 8 cycles after the last ctr_0 clear.
2. Immediate request:
   - Stimulus: dly_en=0; stop activity.
   - Required: DELAY for 1 cycle, then REQ with rst_req=1 and rst_cnt=1.
   - Stimulus: pulse rst_ack at edge n.
   - Required: state=ACKED and rst_req=0 after edge n+1.
   - Stimulus: resume toggling.
   - Required: state returns to RUN.
3. Delayed request: dly_en=1; stop activity -> 13 cycles in DELAY (dly_ctr reaches 12), then REQ.
4. Abort: dly_en=1; resume act_in[0] toggles during DELAY at dly_ctr=5 -> back to RUN; rst_req never high; rst_cnt unchanged.
5. Channel masking:
   - Stimulus: ch_en=11 with ch0 quiet and ch1 toggling.
   - Required: idle=01, sys_rst=0.
   - Stimulus: ch_en=10.
   - Required: sys_rst=0.
   - Stimulus: ch_en=01.
   - Required: sys_rst=1 next cycle.
   - Stimulus: ch_en=00.
   - Required: sys_rst=0.
6. Reset and saturation:
   - Stimulus: complete 4 request/ack cycles.
   - Required: rst_cnt stays 3 after the third.
   - Stimulus: assert rst while in REQ.
   - Required: next cycle state=RUN, rst_req=0, rst_cnt=0, idle=0.
